// File: rtl/bcd_seq_converter_if.sv
// Handshake and result bundle between the processor-side mux and the
// sequential binary-to-BCD converter.
interface bcd_seq_converter_if #(
  parameter int N_BITS = 8,
  parameter int DIGITS = 3
);
  logic                  START;
  logic [N_BITS-1:0]     DATA;
  logic                  BUSY;
  logic                  DONE;
  logic [7:0]            DATA_BCD;
  logic [4*DIGITS-1:0]   BCD_FULL;
  logic                  OVF;

  // Processor / mux side: requests conversions and reads the results.
  modport master (
    output START, DATA,
    input  BUSY, DONE, DATA_BCD, BCD_FULL, OVF
  );

  // Converter side.
  modport slave (
    input  START, DATA,
    output BUSY, DONE, DATA_BCD, BCD_FULL, OVF
  );
endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. A conversion takes N_BITS clocks after START is accepted; results
// stay registered until the next completion or reset.
module bcd_seq_converter #(
  parameter int N_BITS = 8,
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_seq_converter_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(N_BITS + 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [N_BITS-1:0]  bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic               last;

  // Add 3 to every digit that is 5 or more, ahead of the shift.
  always_comb begin
    // NOTE: default first so every path assigns bcd_adj -- no latch inferred.
    bcd_adj = bcd_sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5)
        bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
    end
  end

  // Shift the adjusted digits left, pulling in the binary MSB; the digit
  // MSB falls off (always zero when 10**DIGITS covers the input range).
  assign bcd_shift = BCD_W'({bcd_adj, bin_sr[N_BITS-1]});
  assign last      = (cnt == CNT_W'(1));

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.START) state_next = CONV;
      CONV: if (last)      state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: capture, shift, and publish the result on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      bin_sr       <= '0;
      bcd_sr       <= '0;
      bus.BUSY     <= 1'b0;
      bus.DONE     <= 1'b0;
      bus.DATA_BCD <= 8'h00;
      bus.BCD_FULL <= '0;
      bus.OVF      <= 1'b0;
    end else begin
      bus.DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.START) begin
            bin_sr   <= bus.DATA;
            bcd_sr   <= '0;
            cnt      <= CNT_W'(N_BITS);
            bus.BUSY <= 1'b1;
          end
        end
        CONV: begin
          bcd_sr <= bcd_shift;
          bin_sr <= bin_sr << 1;
          cnt    <= cnt - CNT_W'(1);
          if (last) begin
            bus.BCD_FULL <= bcd_shift;
            bus.DATA_BCD <= bcd_shift[7:0];
            bus.OVF      <= |bcd_shift[BCD_W-1:8];
            bus.DONE     <= 1'b1;
            bus.BUSY     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed self-checking bench for bcd_seq_converter.
module tb_bcd_seq_converter;

  logic clk = 1'b0;
  logic reset;

  bcd_seq_converter_if #(.N_BITS(8), .DIGITS(3)) bif ();

  bcd_seq_converter #(.N_BITS(8), .DIGITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Caller is positioned #1 after an edge. Issues START for one edge, then
  // scrambles DATA and waits (bounded) for DONE. Reports latency in edges
  // after the accepting edge (-1 on timeout) and whether DATA_BCD held still.
  task automatic convert(input logic [7:0] v, output int lat, output logic stable);
    logic [7:0] prev;
    prev       = bif.DATA_BCD;
    bif.START  = 1'b1;
    bif.DATA   = v;
    @(posedge clk); #1;
    bif.START  = 1'b0;
    bif.DATA   = 8'($urandom);
    lat        = -1;
    stable     = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bif.DONE) begin
        lat = k;
        break;
      end
      if (bif.DATA_BCD !== prev) stable = 1'b0;
    end
  endtask

  int         lat;
  logic       stable;
  int         done_cnt;
  int         done_cyc;
  logic [7:0] done_bcd;

  initial begin
    reset     = 1'b1;
    bif.START = 1'b0;
    bif.DATA  = '0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bif.BUSY), 32'd0);
    check("rst_done", 32'(bif.DONE), 32'd0);
    check("rst_bcd",  32'(bif.DATA_BCD), 32'h00);
    check("rst_full", 32'(bif.BCD_FULL), 32'h000);
    check("rst_ovf",  32'(bif.OVF), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 2a/2b: basic conversions
    convert(8'd0, lat, stable);
    check("c0_lat", 32'(lat), 32'd8);
    check("c0_bcd", 32'(bif.DATA_BCD), 32'h00);
    check("c0_ovf", 32'(bif.OVF), 32'd0);
    check("c0_busy", 32'(bif.BUSY), 32'd0);
    @(posedge clk); #1;
    check("done_pulse", 32'(bif.DONE), 32'd0);

    convert(8'd99, lat, stable);
    check("c99_lat", 32'(lat), 32'd8);
    check("c99_bcd", 32'(bif.DATA_BCD), 32'h99);
    check("c99_ovf", 32'(bif.OVF), 32'd0);
    @(posedge clk); #1;

    // 3a/3b: overflow
    convert(8'd255, lat, stable);
    check("c255_full", 32'(bif.BCD_FULL), 32'h255);
    check("c255_bcd",  32'(bif.DATA_BCD), 32'h55);
    check("c255_ovf",  32'(bif.OVF), 32'd1);
    @(posedge clk); #1;
    convert(8'd100, lat, stable);
    check("c100_full", 32'(bif.BCD_FULL), 32'h100);
    check("c100_bcd",  32'(bif.DATA_BCD), 32'h00);
    check("c100_ovf",  32'(bif.OVF), 32'd1);
    @(posedge clk); #1;

    // 4a: START during BUSY is ignored
    bif.START = 1'b1;
    bif.DATA  = 8'd37;
    @(posedge clk); #1;
    check("busy_set", 32'(bif.BUSY), 32'd1);
    check("bcd_kept_at_start", 32'(bif.DATA_BCD), 32'h00);
    done_cnt = 0;
    done_cyc = -1;
    done_bcd = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      bif.START = (c == 3);
      bif.DATA  = (c == 3) ? 8'd42 : 8'd0;
      @(posedge clk); #1;
      if (bif.DONE) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          done_bcd = bif.DATA_BCD;
          break;
        end
      end
    end
    bif.START = 1'b0;
    check("ign_done_cyc", 32'(done_cyc), 32'd8);
    check("ign_bcd", 32'(done_bcd), 32'h37);

    // 4b: START accepted in the DONE cycle
    convert(8'd58, lat, stable);
    check("b2b_lat", 32'(lat), 32'd8);
    check("b2b_bcd", 32'(bif.DATA_BCD), 32'h58);
    check("b2b_stable", 32'(stable), 32'd1);
    // Confirm no second DONE from the ignored START earlier.
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bif.DONE) done_cnt++;
    end
    check("ign_one_done", 32'(done_cnt), 32'd1);

    // 5: reset mid-conversion
    bif.START = 1'b1;
    bif.DATA  = 8'd73;
    @(posedge clk); #1;
    bif.START = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_busy", 32'(bif.BUSY), 32'd0);
    check("mid_rst_bcd",  32'(bif.DATA_BCD), 32'h00);
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (bif.DONE) done_cnt++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    convert(8'd64, lat, stable);
    check("after_rst_bcd", 32'(bif.DATA_BCD), 32'h64);
    check("after_rst_lat", 32'(lat), 32'd8);

    // 6: exhaustive, back-to-back from each DONE cycle
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), lat, stable);
      check($sformatf("ex%0d_lat", v), 32'(lat), 32'd8);
      check($sformatf("ex%0d_full", v), 32'(bif.BCD_FULL), 32'(ref_bcd(v)));
      check($sformatf("ex%0d_bcd", v), 32'(bif.DATA_BCD), 32'(ref_bcd(v) & 12'h0FF));
      check($sformatf("ex%0d_ovf", v), 32'(bif.OVF), 32'(v > 99));
      check($sformatf("ex%0d_stable", v), 32'(stable), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
